// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared types and constants for the CPU input-port feeder
// Purpose: FSM state encoding for in_port_feeder, the minimum setup depth
//          shared with the CPU's two-stage input sampler, and a small max helper.
// Ports:   none (package).
package cpu_io_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} feeder_state_t;

  // The CPU registers in_port through two flops, so data must lead ready by at
  // least this many cycles for the sampled byte to match the ready edge.
  localparam int MIN_SETUP_CYCLES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
// Purpose: small byte queue between the host source and the feeder FSM.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push_i, wr_data_i     write strobe and data (ignored when full)
//   pop_i, rd_data_o      read strobe (ignored when empty), head-of-queue data
//   full_o, empty_o       derived from the registered count
//   count_o               occupied entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/in_port_feeder.sv
// rtl/in_port_feeder.sv - queues host bytes and presents them to the CPU input port
// Purpose: pops one byte at a time from a FIFO, holds it on out_data, and after
//          SETUP_CYCLES raises ready_out for HIGH_CYCLES, then keeps it low for
//          LOW_CYCLES before taking the next byte.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_valid, wr_data     upstream byte; accepted when wr_ready is also high
//   wr_ready              FIFO not full (forced low while reset is high)
//   out_data              byte presented to the CPU in_port (registered)
//   ready_out             one registered pulse per byte to the CPU ready_in
//   busy                  FSM is not IDLE
//   fifo_count            bytes waiting in the FIFO
module in_port_feeder
  import cpu_io_pkg::*;
#(
  parameter int BUS_WIDTH    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 2,
  parameter int LOW_CYCLES   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [BUS_WIDTH-1:0]        wr_data,
  output logic                        wr_ready,
  output logic [BUS_WIDTH-1:0]        out_data,
  output logic                        ready_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, HIGH_CYCLES, LOW_CYCLES) + 1);

  if (SETUP_CYCLES < MIN_SETUP_CYCLES) begin : g_bad_setup
    $error("in_port_feeder: SETUP_CYCLES must be >= %0d", MIN_SETUP_CYCLES);
  end
  if (HIGH_CYCLES < 1) begin : g_bad_high
    $error("in_port_feeder: HIGH_CYCLES must be >= 1");
  end
  if (LOW_CYCLES < 1) begin : g_bad_low
    $error("in_port_feeder: LOW_CYCLES must be >= 1");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("in_port_feeder: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  feeder_state_t          state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BUS_WIDTH-1:0]   out_data_q;
  logic                   ready_q;

  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [BUS_WIDTH-1:0]   fifo_head;

  assign wr_ready  = ~fifo_full & ~reset;
  assign fifo_push = wr_valid & wr_ready;
  // The head is taken only from IDLE, so the byte in flight is never disturbed.
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;

  sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (fifo_push),
    .wr_data_i (wr_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // cnt_q holds the remaining cycles of the current phase minus one; each phase
  // ends on the cycle where it reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (!fifo_empty) begin
            out_data_q <= fifo_head;
            cnt_q      <= CNT_W'(SETUP_CYCLES - 1);
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(HIGH_CYCLES - 1);
            ready_q <= 1'b1;
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNT_W'(LOW_CYCLES - 1);
            ready_q <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign ready_out = ready_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_in_port_feeder.sv
// tb/tb_in_port_feeder.sv - directed self-checking bench for in_port_feeder
module tb_in_port_feeder;

  localparam int PERIOD = 1 + 2 + 2 + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] out_data;
  logic       ready_out;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  in_port_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .out_data   (out_data),
    .ready_out  (ready_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Rising-edge log of ready_out with the byte present at that moment.
  int         cyc = 0;
  logic       rdy_prev = 1'b0;
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];

  always @(negedge clk) begin
    if (ready_out && !rdy_prev) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(out_data);
    end
    rdy_prev <= ready_out;
    cyc      <= cyc + 1;
  end

  // CPU-side reader: two-stage sync of ready and data, store on ready rise.
  logic [1:0] rdy_sync = 2'b00;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic [7:0] cpu_reg = 8'h00;
  logic [7:0] cpu_q[$];

  always @(posedge clk) begin
    rdy_sync <= {rdy_sync[0], ready_out};
    d1       <= out_data;
    d2       <= d1;
    if (rdy_sync[0] && !rdy_sync[1]) begin
      cpu_reg <= d2;
      cpu_q.push_back(d2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && n < 100) begin
      step();
      n++;
    end
    check("push_timeout", 32'(n < 100), 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || fifo_count != 3'd0) && n < 200) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic wait_busy_low();
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    check("busy_low_timeout", 32'(n < 50), 32'd1);
  endtask

  initial begin
    int         base;
    int         n;
    logic [7:0] exp_seq[7];

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    step();
    step();
    check("wr_ready_in_reset", 32'(wr_ready), 32'd0);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outputs", 32'({ready_out, out_data, wr_ready, fifo_count, busy}),
            32'({1'b0, 8'h00, 1'b1, 3'd0, 1'b0}));
    end

    // 2: single byte timing; n counts negedges after the push edge
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("single_ready_n%0d", k), 32'(ready_out), 32'((k == 3) || (k == 4)));
      check($sformatf("single_busy_n%0d", k), 32'(busy), 32'((k >= 1) && (k <= 6)));
      check($sformatf("single_data_n%0d", k), 32'(out_data), (k >= 1) ? 32'hA5 : 32'h00);
      step();
    end

    // 3: five back-to-back bytes
    wait_idle();
    base = rise_dat.size();
    for (int i = 1; i <= 5; i++) begin
      check("burst_wr_ready", 32'(wr_ready), 32'd1);
      push_byte(8'(i));
    end
    check("burst_count_full", 32'(fifo_count), 32'd4);
    check("burst_wr_ready_full", 32'(wr_ready), 32'd0);
    n = 0;
    while (rise_dat.size() < base + 5 && n < 100) begin
      step();
      n++;
    end
    check("burst_rise_timeout", 32'(n < 100), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (base + i < rise_dat.size())
        check($sformatf("burst_data_%0d", i), 32'(rise_dat[base+i]), 32'(i + 1));
      if (i > 0 && base + i < rise_cyc.size())
        check($sformatf("burst_period_%0d", i), 32'(rise_cyc[base+i] - rise_cyc[base+i-1]),
              32'(PERIOD));
    end

    // 6: full FIFO at the pop edge, then push and pop in the same cycle
    wait_idle();
    base = rise_dat.size();
    for (int i = 0; i < 5; i++) push_byte(8'h11 + 8'(i));
    wr_data  = 8'h16;
    wr_valid = 1'b1;
    wait_busy_low();
    check("full_at_idle_count", 32'(fifo_count), 32'd4);
    check("full_at_idle_wr_ready", 32'(wr_ready), 32'd0);
    step();
    check("after_pop_count", 32'(fifo_count), 32'd3);
    check("after_pop_wr_ready", 32'(wr_ready), 32'd1);
    step();
    check("refill_count", 32'(fifo_count), 32'd4);
    check("refill_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b0;
    wait_busy_low();
    step();
    wait_busy_low();
    check("pushpop_pre_count", 32'(fifo_count), 32'd3);
    wr_data  = 8'h17;
    wr_valid = 1'b1;
    check("pushpop_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    check("pushpop_count", 32'(fifo_count), 32'd3);
    wait_idle();
    step();
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    check("order_num_rises", 32'(rise_dat.size() - base), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (base + i < rise_dat.size())
        check($sformatf("order_data_%0d", i), 32'(rise_dat[base+i]), 32'(exp_seq[i]));
    end

    // 4: CPU-side edge-detect reader
    base = cpu_q.size();
    push_byte(8'h3C);
    push_byte(8'hC3);
    wait_idle();
    for (int i = 0; i < 6; i++) step();
    check("cpu_num_bytes", 32'(cpu_q.size() - base), 32'd2);
    if (cpu_q.size() >= base + 2) begin
      check("cpu_byte_0", 32'(cpu_q[base]), 32'h3C);
      check("cpu_byte_1", 32'(cpu_q[base+1]), 32'hC3);
    end
    check("cpu_reg_last", 32'(cpu_reg), 32'hC3);

    // 5: reset during STROBE with two bytes queued
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    n = 0;
    while (!ready_out && n < 50) begin
      step();
      n++;
    end
    check("strobe_timeout", 32'(n < 50), 32'd1);
    check("strobe_queued", 32'(fifo_count), 32'd2);
    reset = 1'b1;
    step();
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    step();
    base = rise_dat.size();
    for (int i = 0; i < 30; i++) step();
    check("post_rst_no_pulse", 32'(rise_dat.size() - base), 32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_wr_ready", 32'(wr_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
